// File: rtl/sha256_feed_pkg.sv
// Shared constants and types for the SHA-256 message feeder and its output FIFO.
package sha256_feed_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int MSG_WORDS  = 10;
  localparam int DIG_WORDS  = 8;
  localparam int PIPE_DEPTH = 10;
  localparam int OUT_DEPTH  = 2;
  localparam int TAG_W      = 4;

  typedef enum logic {
    FILL  = 1'b0,
    ISSUE = 1'b1
  } feed_state_e;

  typedef struct packed {
    logic [TAG_W-1:0]                tag;
    logic [DIG_WORDS*DATA_WIDTH-1:0] digest;
  } fifo_entry_t;

endpackage

// File: rtl/sha_feed_fifo.sv
// Show-ahead FIFO with occupancy count; head entry is visible whenever the FIFO is not empty.
module sha_feed_fifo #(
  parameter int  WIDTH = 8,
  parameter int  DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  output logic [CW-1:0]    count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, empty, do_push, do_pop;

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // A pop frees the head slot on the same edge, so a full FIFO may still accept.
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = next_ptr(wr_ptr_q);
    if (do_pop)  rd_ptr_d = next_ptr(rd_ptr_q);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = empty ? '0 : mem_q[rd_ptr_q];
  assign valid_o = !empty;
  assign count_o = count_q;

  overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && full && !pop_i));

endmodule

// File: rtl/sha256_msg_feeder.sv
// Packs streamed words into messages, launches them into the fixed-latency SHA-256 pipeline
// and queues tagged digests for the consumer. SHA_FEED_BYTESWAP_EN byte-reverses input words.
module sha256_msg_feeder #(
  parameter int DATA_WIDTH = sha256_feed_pkg::DATA_WIDTH,
  parameter int MSG_WORDS  = sha256_feed_pkg::MSG_WORDS,
  parameter int DIG_WORDS  = sha256_feed_pkg::DIG_WORDS,
  parameter int PIPE_DEPTH = sha256_feed_pkg::PIPE_DEPTH,
  parameter int OUT_DEPTH  = sha256_feed_pkg::OUT_DEPTH,
  parameter int TAG_W      = sha256_feed_pkg::TAG_W
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_WIDTH-1:0]           in_data,
  output logic [MSG_WORDS*DATA_WIDTH-1:0] pipe_message,
  output logic                            pipe_launch,
  input  logic [DIG_WORDS*DATA_WIDTH-1:0] pipe_digest,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DIG_WORDS*DATA_WIDTH-1:0] out_digest,
  output logic [TAG_W-1:0]                out_tag
);

  import sha256_feed_pkg::*;

  localparam int IDX_W = (MSG_WORDS > 1) ? $clog2(MSG_WORDS) : 1;
  localparam int CNT_W = $clog2(OUT_DEPTH + 1);
  localparam int DIG_W = DIG_WORDS * DATA_WIDTH;
  localparam int ENT_W = TAG_W + DIG_W;

  feed_state_e           state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [TAG_W-1:0]      tag_q;
  logic [CNT_W-1:0]      inflight_q;
  logic [CNT_W-1:0]      fifo_count;
  logic [DATA_WIDTH-1:0] msg_q [MSG_WORDS];
  logic [PIPE_DEPTH-1:0] trk_vld_q;
  logic [TAG_W-1:0]      trk_tag_q [PIPE_DEPTH];
  logic [DATA_WIDTH-1:0] word_in;
  logic [ENT_W-1:0]      fifo_dout;
  logic                  accept, credit_ok, capture;

  genvar gi;

`ifdef SHA_FEED_BYTESWAP_EN
  for (gi = 0; gi < DATA_WIDTH / 8; gi++) begin : g_swap
    assign word_in[gi*8 +: 8] = in_data[DATA_WIDTH-8-gi*8 +: 8];
  end
`else
  assign word_in = in_data;
`endif

  // Every message in flight owns a FIFO slot, so a capture can never find the FIFO full.
  // Registered counts only: a pop on this edge frees credit for the next cycle.
  assign credit_ok = ({1'b0, inflight_q} + {1'b0, fifo_count}) < (CNT_W + 1)'(OUT_DEPTH);
  assign capture   = trk_vld_q[PIPE_DEPTH-1];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    in_ready    = 1'b0;
    pipe_launch = 1'b0;
    accept      = 1'b0;
    case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          if (idx_q == IDX_W'(MSG_WORDS - 1)) begin
            idx_d   = '0;
            state_d = ISSUE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ISSUE: begin
        if (credit_ok) begin
          pipe_launch = 1'b1;
          state_d     = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= FILL;
      idx_q      <= '0;
      tag_q      <= '0;
      inflight_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (pipe_launch) tag_q <= tag_q + TAG_W'(1);
      case ({pipe_launch, capture})
        2'b10:   inflight_q <= inflight_q + CNT_W'(1);
        2'b01:   inflight_q <= inflight_q - CNT_W'(1);
        default: inflight_q <= inflight_q;
      endcase
    end
  end

  for (gi = 0; gi < MSG_WORDS; gi++) begin : g_slot
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        msg_q[gi] <= '0;
      end else if (accept && (idx_q == IDX_W'(gi))) begin
        msg_q[gi] <= word_in;
      end
    end
    assign pipe_message[gi*DATA_WIDTH +: DATA_WIDTH] = msg_q[gi];
  end

  // Tracking line mirrors the pipeline: a valid bit reaches the tail exactly when its digest does.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trk_vld_q[0] <= 1'b0;
      trk_tag_q[0] <= '0;
    end else begin
      trk_vld_q[0] <= pipe_launch;
      trk_tag_q[0] <= tag_q;
    end
  end

  for (gi = 1; gi < PIPE_DEPTH; gi++) begin : g_trk
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        trk_vld_q[gi] <= 1'b0;
        trk_tag_q[gi] <= '0;
      end else begin
        trk_vld_q[gi] <= trk_vld_q[gi-1];
        trk_tag_q[gi] <= trk_tag_q[gi-1];
      end
    end
  end

  sha_feed_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (capture),
    .din_i   ({trk_tag_q[PIPE_DEPTH-1], pipe_digest}),
    .pop_i   (out_ready),
    .dout_o  (fifo_dout),
    .valid_o (out_valid),
    .count_o (fifo_count)
  );

  assign out_tag    = fifo_dout[ENT_W-1 -: TAG_W];
  assign out_digest = fifo_dout[DIG_W-1:0];

endmodule

// File: tb/tb_sha256_msg_feeder.sv
// Bench for sha256_msg_feeder: pipeline stub, queue-based reference model and directed/random stimulus.
module tb_sha256_msg_feeder;
  import sha256_feed_pkg::*;

  localparam int DW  = 32;
  localparam int MW  = 10;
  localparam int DGW = 8;
  localparam int PD  = 10;
  localparam int OD  = 2;
  localparam int TW  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DW-1:0]     in_data = '0;
  logic [MW*DW-1:0]  pipe_message;
  logic              pipe_launch;
  logic [DGW*DW-1:0] pipe_digest;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DGW*DW-1:0] out_digest;
  logic [TW-1:0]     out_tag;

  always #5 clk = ~clk;

  sha256_msg_feeder #(
    .DATA_WIDTH (DW),
    .MSG_WORDS  (MW),
    .DIG_WORDS  (DGW),
    .PIPE_DEPTH (PD),
    .OUT_DEPTH  (OD),
    .TAG_W      (TW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .pipe_message (pipe_message),
    .pipe_launch  (pipe_launch),
    .pipe_digest  (pipe_digest),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_digest   (out_digest),
    .out_tag      (out_tag)
  );

  // Pipeline stub: free-running, returns message words 0..7 PD edges after sampling.
  logic [MW*DW-1:0] stub_q [PD];
  always @(posedge clk) begin
    stub_q[0] <= pipe_message;
    for (int i = 1; i < PD; i++) stub_q[i] <= stub_q[i-1];
  end
  assign pipe_digest = stub_q[PD-1][DGW*DW-1:0];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [319:0] got, input logic [319:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [31:0] swap_w(input logic [31:0] w);
`ifdef SHA_FEED_BYTESWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  // Reference model: message under assembly, launched messages with capture edge, output queue.
  typedef struct {
    int unsigned       cap;
    logic [TW-1:0]     tag;
    logic [DGW*DW-1:0] dig;
  } fly_t;

  logic [DW-1:0] m_msg [MW];
  int            m_cnt = 0;
  bit            m_pend = 1'b0;
  logic [TW-1:0] m_tag = '0;
  int unsigned   edge_n = 0;
  fly_t          m_fly [$];
  fifo_entry_t   m_outq [$];
  logic [TW-1:0] tag_log [$];

  always @(negedge clk) begin
    logic [MW*DW-1:0] e_msg;
    logic             e_rdy, e_launch, e_ov;
    fifo_entry_t      ent;
    fly_t             f;
    if (!reset) begin
      m_cnt  = 0;
      m_pend = 1'b0;
      m_tag  = '0;
      m_fly.delete();
      m_outq.delete();
      for (int k = 0; k < MW; k++) m_msg[k] = '0;
      chk("rst_launch", 320'(pipe_launch), 320'(0));
      chk("rst_out_valid", 320'(out_valid), 320'(0));
      chk("rst_out_digest", 320'(out_digest), 320'(0));
      chk("rst_out_tag", 320'(out_tag), 320'(0));
      chk("rst_pipe_message", 320'(pipe_message), 320'(0));
    end else begin
      for (int k = 0; k < MW; k++) e_msg[k*DW +: DW] = m_msg[k];
      e_rdy    = !m_pend;
      e_launch = m_pend && ((m_fly.size() + m_outq.size()) < OD);
      e_ov     = (m_outq.size() != 0);
      chk("in_ready", 320'(in_ready), 320'(e_rdy));
      chk("pipe_launch", 320'(pipe_launch), 320'(e_launch));
      chk("pipe_message", 320'(pipe_message), 320'(e_msg));
      chk("out_valid", 320'(out_valid), 320'(e_ov));
      if (e_ov) begin
        chk("out_tag", 320'(out_tag), 320'(m_outq[0].tag));
        chk("out_digest", 320'(out_digest), 320'(m_outq[0].digest));
      end
      if (out_valid && out_ready) begin
        tag_log.push_back(out_tag);
        $display("xfer t=%0t tag=%0d dig0=%08h dig7=%08h", $time, out_tag,
                 out_digest[31:0], out_digest[255:224]);
      end
      edge_n++;
      if (e_ov && out_ready) void'(m_outq.pop_front());
      while (m_fly.size() != 0 && m_fly[0].cap == edge_n) begin
        ent.tag    = m_fly[0].tag;
        ent.digest = m_fly[0].dig;
        m_outq.push_back(ent);
        void'(m_fly.pop_front());
      end
      if (e_launch) begin
        f.cap = edge_n + PD;
        f.tag = m_tag;
        f.dig = e_msg[DGW*DW-1:0];
        m_fly.push_back(f);
        m_tag  = m_tag + 1'b1;
        m_pend = 1'b0;
      end else if (e_rdy && in_valid) begin
        m_msg[m_cnt] = swap_w(in_data);
        if (m_cnt == MW - 1) begin
          m_cnt  = 0;
          m_pend = 1'b1;
        end else begin
          m_cnt++;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the last word is accepted.
  task automatic send_msg(input logic [31:0] base, input bit rnd);
    for (int k = 0; k < MW; k++) begin
      bit done;
      int n;
      in_valid = 1'b1;
      in_data  = rnd ? $urandom : base + 32'h01010101 * 32'(k);
      done = 1'b0;
      n    = 0;
      while (!done && n < 200) begin
        @(negedge clk);
        done = in_ready;
        @(posedge clk);
        #1;
        n++;
      end
      if (!done) chk("send_timeout", 320'(done), 320'(1));
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    bit seen_ov;
    logic [31:0] e_swap;

    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    // First message at one word per cycle
    send_msg(32'h41414141, 1'b0);
    @(negedge clk);
    chk("A_launch", 320'(pipe_launch), 320'(1));
    chk("A_word0", 320'(pipe_message[31:0]), 320'(32'h41414141));
    chk("A_word9", 320'(pipe_message[319:288]), 320'(32'h4a4a4a4a));
    @(posedge clk);
    #1;
    repeat (9) @(posedge clk);
    #1 chk("A_ov_before", 320'(out_valid), 320'(0));
    @(posedge clk);
    #1;
    chk("A_ov", 320'(out_valid), 320'(1));
    chk("A_tag", 320'(out_tag), 320'(0));
    chk("A_dig0", 320'(out_digest[31:0]), 320'(32'h41414141));
    chk("A_dig7", 320'(out_digest[255:224]), 320'(32'h48484848));

    // Back-pressure: two digests queue, third message waits for credit
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b0;
    send_msg(32'h0, 1'b1);
    send_msg(32'h0, 1'b1);
    send_msg(32'h0, 1'b1);
    repeat (25) @(posedge clk);
    #1;
    chk("B_in_ready", 320'(in_ready), 320'(0));
    chk("B_launch_blocked", 320'(pipe_launch), 320'(0));
    chk("B_ov", 320'(out_valid), 320'(1));
    chk("B_head_tag", 320'(out_tag), 320'(1));
    out_ready = 1'b1;
    chk("B_pop_not_credited", 320'(pipe_launch), 320'(0));
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk("B_launch_after_pop", 320'(pipe_launch), 320'(1));
    chk("B_next_tag", 320'(out_tag), 320'(2));
    repeat (4) @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1 chk("B_drained", 320'(out_valid), 320'(0));

    // Tag wrap over 17 messages, starting from reset
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    base = tag_log.size();
    for (int m = 0; m < 17; m++) send_msg(32'h0, 1'b1);
    n = 0;
    while (tag_log.size() < base + 17 && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("C_count", 320'(tag_log.size() - base), 320'(17));
    for (int i = 0; i < 17; i++) begin
      if (base + i < tag_log.size())
        chk("C_tag_seq", 320'(tag_log[base+i]), 320'(i % 16));
    end

    // Reset 5 cycles after a launch discards the in-flight message
    send_msg(32'h0, 1'b1);
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    chk("D_in_ready", 320'(in_ready), 320'(1));
    seen_ov = 1'b0;
    repeat (25) begin
      @(negedge clk);
      seen_ov = seen_ov | out_valid;
    end
    @(posedge clk);
    #1;
    chk("D_no_digest", 320'(seen_ov), 320'(0));
    send_msg(32'h0, 1'b1);
    @(negedge clk);
    chk("D_idx_restart", 320'(pipe_launch), 320'(1));
    @(posedge clk);
    #1;
    repeat (20) @(posedge clk);
    #1;

    // Byte order of stored words
`ifdef SHA_FEED_BYTESWAP_EN
    e_swap = 32'h04030201;
`else
    e_swap = 32'h01020304;
`endif
    send_msg(32'h01020304, 1'b0);
    @(negedge clk);
    chk("E_word0_order", 320'(pipe_message[31:0]), 320'(e_swap));
    @(posedge clk);
    #1;
    repeat (20) @(posedge clk);
    #1;

    // Random traffic with random back-pressure
    for (int c = 0; c < 2000; c++) begin
      in_valid  = ($urandom % 4) != 0;
      in_data   = $urandom;
      out_ready = (c % 400 < 200) ? (($urandom % 4) == 0) : (($urandom % 3) != 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
